// File: rtl/mmind_pkg.sv
// Shared types and constants for the mmind code-guessing core.
// Segment patterns are active-low {a,b,c,d,e,f,g}.
package mmind_pkg;

  localparam int NUM_POS    = 4;
  localparam int COLOR_W    = 2;
  localparam int CODE_W     = NUM_POS * COLOR_W;
  localparam int NUM_COLORS = 1 << COLOR_W;

  typedef enum logic [1:0] {
    NO_ANS  = 2'd0,
    ANS_SET = 2'd1,
    RESULT  = 2'd2,
    WIN     = 2'd3
  } state_e;

  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_D0   = 7'b0000001;
  localparam logic [6:0] SEG_D1   = 7'b1001111;
  localparam logic [6:0] SEG_D2   = 7'b0010010;
  localparam logic [6:0] SEG_D3   = 7'b0000110;
  localparam logic [6:0] SEG_D4   = 7'b1001100;

  // Only 0..4 are reachable; anything else falls back to the dash.
  function automatic logic [6:0] seg_digit(input logic [2:0] d);
    case (d)
      3'd0:    seg_digit = SEG_D0;
      3'd1:    seg_digit = SEG_D1;
      3'd2:    seg_digit = SEG_D2;
      3'd3:    seg_digit = SEG_D3;
      3'd4:    seg_digit = SEG_D4;
      default: seg_digit = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/mmind_score.sv
// Combinational scorer: exact (colour+position) hits and colour-only hits
// between a stored answer and a guess.
module mmind_score
  import mmind_pkg::*;
(
  input  logic [CODE_W-1:0] answer,
  input  logic [CODE_W-1:0] guess,
  output logic [2:0]        exact,
  output logic [2:0]        white
);

  logic [NUM_POS-1:0] hit;
  logic [2:0]         cnt_a;
  logic [2:0]         cnt_g;
  logic [2:0]         common;

  genvar i;
  generate
    for (i = 0; i < NUM_POS; i++) begin : g_pos
      assign hit[i] = answer[i*COLOR_W +: COLOR_W] == guess[i*COLOR_W +: COLOR_W];
    end
  endgenerate

  always_comb begin
    exact  = '0;
    common = '0;
    cnt_a  = '0;
    cnt_g  = '0;
    for (int p = 0; p < NUM_POS; p++)
      exact = exact + {2'b00, hit[p]};
    // Total colour overlap is the per-colour minimum of the two histograms.
    for (int c = 0; c < NUM_COLORS; c++) begin
      cnt_a = '0;
      cnt_g = '0;
      for (int p = 0; p < NUM_POS; p++) begin
        if (answer[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_a = cnt_a + 3'd1;
        if (guess[p*COLOR_W +: COLOR_W]  == COLOR_W'(c)) cnt_g = cnt_g + 3'd1;
      end
      common = common + ((cnt_a < cnt_g) ? cnt_a : cnt_g);
    end
    white = common - exact;
  end

endmodule

// File: rtl/mmind.sv
// Mastermind game core: button edge detect, game FSM, scorer, and a
// registered active-low 7-segment driver.
module mmind
  import mmind_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              setans_btn,
  input  logic              guess_btn,
  input  logic [CODE_W-1:0] switches,
  output logic              ca,
  output logic              cb,
  output logic              cc,
  output logic              cd,
  output logic              ce,
  output logic              cf,
  output logic              cg
);

  logic              set_q, guess_q;
  logic              set_ev, guess_ev;
  state_e            state_q;
  logic [CODE_W-1:0] answer_q;
  logic [2:0]        exact_q, white_q;
  logic [2:0]        exact_n, white_n;
  logic [6:0]        seg_q;

  mmind_score u_score (
    .answer (answer_q),
    .guess  (switches),
    .exact  (exact_n),
    .white  (white_n)
  );

  // Press events are registered, so the FSM acts one edge after detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_q    <= 1'b0;
      guess_q  <= 1'b0;
      set_ev   <= 1'b0;
      guess_ev <= 1'b0;
    end else begin
      set_q    <= setans_btn;
      guess_q  <= guess_btn;
      set_ev   <= setans_btn & ~set_q;
      guess_ev <= guess_btn & ~guess_q;
    end
  end

  // Loading an answer takes priority over any guess in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= NO_ANS;
      answer_q <= '0;
      exact_q  <= '0;
      white_q  <= '0;
    end else if (set_ev) begin
      state_q  <= ANS_SET;
      answer_q <= switches;
      exact_q  <= '0;
      white_q  <= '0;
    end else if (guess_ev && (state_q == ANS_SET || state_q == RESULT)) begin
      state_q  <= (exact_n == 3'(NUM_POS)) ? WIN : RESULT;
      exact_q  <= exact_n;
      white_q  <= white_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_DASH;
    end else begin
      case (state_q)
        NO_ANS:  seg_q <= SEG_DASH;
        ANS_SET: seg_q <= SEG_A;
        RESULT:  seg_q <= seg_digit(exact_q);
        WIN:     seg_q <= SEG_D4;
        default: seg_q <= SEG_DASH;
      endcase
    end
  end

  assign {ca, cb, cc, cd, ce, cf, cg} = seg_q;

endmodule

// File: tb/tb_mmind.sv
// Directed and random stimulus for mmind against a game-level reference model.
module tb_mmind;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       setans_btn = 1'b0;
  logic       guess_btn = 1'b0;
  logic [7:0] switches = 8'h00;
  logic       ca, cb, cc, cd, ce, cf, cg;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0=no answer, 1=answer set, 2=showing result, 3=won
  int         m_phase = 0;
  logic [7:0] m_ans   = 8'h00;
  int         m_exact = 0;
  int         m_white = 0;

  mmind dut (
    .clk        (clk),
    .reset      (reset),
    .setans_btn (setans_btn),
    .guess_btn  (guess_btn),
    .switches   (switches),
    .ca (ca), .cb (cb), .cc (cc), .cd (cd), .ce (ce), .cf (cf), .cg (cg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int phase, input int ex);
    logic [6:0] digits [5];
    digits = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    case (phase)
      0:       return 7'b1111110;
      1:       return 7'b0001000;
      2:       return digits[ex];
      default: return 7'b1001100;
    endcase
  endfunction

  function automatic void ref_score(input logic [7:0] a, input logic [7:0] g,
                                    output int ex, output int wh);
    int ha [4];
    int hg [4];
    int tot;
    ex = 0; tot = 0;
    for (int c = 0; c < 4; c++) begin ha[c] = 0; hg[c] = 0; end
    for (int p = 0; p < 4; p++) begin
      int av, gv;
      av = int'((a >> (2*p)) & 8'h3);
      gv = int'((g >> (2*p)) & 8'h3);
      if (av == gv) ex++;
      ha[av]++;
      hg[gv]++;
    end
    for (int c = 0; c < 4; c++) tot += (ha[c] < hg[c]) ? ha[c] : hg[c];
    wh = tot - ex;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_now();
    return {1'b0, ca, cb, cc, cd, ce, cf, cg};
  endfunction

  // One button action: inputs applied before edge N, checked after N+1 and N+2.
  task automatic press(input string tag, input bit s, input bit g,
                       input logic [7:0] sw, input int hold);
    logic [6:0] old_seg;
    int ex, wh;
    old_seg = exp_seg(m_phase, m_exact);
    @(negedge clk);
    switches = sw; setans_btn = s; guess_btn = g;
    @(posedge clk);
    @(negedge clk);
    if (hold == 1) begin setans_btn = 1'b0; guess_btn = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    setans_btn = 1'b0; guess_btn = 1'b0;
    chk({tag, "_lat"}, seg_now(), {1'b0, old_seg});
    if (s) begin
      m_ans = sw; m_phase = 1; m_exact = 0; m_white = 0;
    end else if (g && (m_phase == 1 || m_phase == 2)) begin
      ref_score(m_ans, sw, ex, wh);
      m_exact = ex; m_white = wh;
      m_phase = (ex == 4) ? 3 : 2;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_seg"}, seg_now(), {1'b0, exp_seg(m_phase, m_exact)});
    chk({tag, "_ans"}, dut.answer_q, m_ans);
    chk({tag, "_white"}, {5'b0, dut.white_q}, 8'(m_white));
  endtask

  initial begin
    #100;
    chk("rst_seg", seg_now(), 8'h7E);
    chk("rst_ans", dut.answer_q, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    press("guess_noans", 1'b0, 1'b1, 8'h00, 1);
    press("set_hold", 1'b1, 1'b0, 8'hC3, 2);
    switches = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("one_load", dut.answer_q, 8'hC3);
    chk("sw_noeffect", seg_now(), 8'h08);

    press("guess_ff", 1'b0, 1'b1, 8'hFF, 1);
    chk("two_seg", seg_now(), 8'h12);
    press("guess_win", 1'b0, 1'b1, 8'hC3, 1);
    chk("win_seg", seg_now(), 8'h4C);
    press("win_ignore", 1'b0, 1'b1, 8'h00, 1);

    press("set_and_guess", 1'b1, 1'b1, 8'h1B, 1);
    chk("sg_ans", dut.answer_q, 8'h1B);
    press("guess_e4", 1'b0, 1'b1, 8'hE4, 1);
    chk("e4_seg", seg_now(), 8'h01);
    chk("e4_white", {5'b0, dut.white_q}, 8'd4);

    press("guess_res", 1'b0, 1'b1, 8'h1A, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_seg", seg_now(), 8'h7E);
    chk("mid_rst_ans", dut.answer_q, 8'h00);
    chk("mid_rst_state", {6'b0, dut.state_q}, 8'h00);
    m_phase = 0; m_ans = 8'h00; m_exact = 0; m_white = 0;
    @(negedge clk);
    reset = 1'b1;

    press("rnd_set0", 1'b1, 1'b0, 8'($urandom), 1);
    for (int k = 0; k < 60; k++) begin
      int r;
      logic [7:0] sw;
      r  = $urandom_range(0, 9);
      sw = 8'($urandom);
      if (r == 8) sw = m_ans;
      press("rnd", (r < 2) || (r == 9), r >= 2, sw, $urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
